tensor_frame_loader: RTL and testbench

Upstream feeder for the combinational 4x4 boolean multiply-accumulate core (`tensor`, OUT = A·B OR C). It accepts operand matrices as a serial stream of 4-bit rows over a valid/ready interface and assembles them into the core's 16-bit flat operand buses. It then waits a configurable settle time, captures the core's result, and streams it back out row by row.

---
 rtl/tensor_frame_loader.sv | 163 ++++++++++++++++
 tb/tb_tensor_frame_loader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tensor_frame_loader.sv
// Serial row loader and result drainer for the 4x4 boolean MAC core (OUT = A.B | C).
// Define TENSOR_CHAIN_EN to add in_chain: 8-beat frames that reuse the previous result as C.
module tensor_frame_loader #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_data,
    input  logic        in_last,
`ifdef TENSOR_CHAIN_EN
    input  logic        in_chain,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_data,
    output logic        out_last,
    output logic        frame_err,
    output logic [15:0] A_flat,
    output logic [15:0] B_flat,
    output logic [15:0] C_flat,
    input  logic [15:0] OUT_flat
);

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        DRAIN
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_k;
    logic [3:0]  r_settle;
    logic [1:0]  r_j;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_c;
    logic [15:0] r_res;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [3:0]  r_out_data;
    logic        r_out_last;
    logic        r_frame_err;

    logic        w_accept;
    logic        w_final_beat;
    logic [3:0]  w_row_lsb;
    logic [1:0]  w_next_j;
    logic [3:0]  w_next_lsb;

    assign w_accept   = in_valid && r_in_ready;
    assign w_row_lsb  = {r_k[1:0], 2'b00};
    assign w_next_j   = r_j + 2'd1;
    assign w_next_lsb = {w_next_j, 2'b00};

`ifdef TENSOR_CHAIN_EN
    logic r_chain;
    logic w_chain;

    // The chain flag is taken live on beat 0 and held for the rest of the frame.
    assign w_chain      = (r_k == 4'd0) ? in_chain : r_chain;
    assign w_final_beat = w_chain ? (r_k == 4'd7) : (r_k == 4'd11);
`else
    assign w_final_beat = (r_k == 4'd11);
`endif

    // NOTE: all state below is sequential and uses non-blocking assignments only;
    // the operand registers are few enough to reset, so the core sees zeros after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= LOAD;
            r_k         <= 4'd0;
            r_settle    <= 4'd0;
            r_j         <= 2'd0;
            r_a         <= 16'd0;
            r_b         <= 16'd0;
            r_c         <= 16'd0;
            r_res       <= 16'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 4'd0;
            r_out_last  <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef TENSOR_CHAIN_EN
            r_chain     <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        case (r_k[3:2])
                            2'd0:    r_a[w_row_lsb +: 4] <= in_data;
                            2'd1:    r_b[w_row_lsb +: 4] <= in_data;
                            default: r_c[w_row_lsb +: 4] <= in_data;
                        endcase
`ifdef TENSOR_CHAIN_EN
                        if (r_k == 4'd0) r_chain <= in_chain;
`endif
                        if (w_final_beat) begin
                            r_k         <= 4'd0;
                            r_settle    <= 4'd0;
                            r_in_ready  <= 1'b0;
                            r_frame_err <= !in_last;
                            r_state     <= SETTLE;
`ifdef TENSOR_CHAIN_EN
                            if (w_chain) r_c <= r_res;
`endif
                        end else if (in_last) begin
                            r_k         <= 4'd0;
                            r_frame_err <= 1'b1;
                        end else begin
                            r_k <= r_k + 4'd1;
                        end
                    end
                end
                SETTLE: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_res       <= OUT_flat;
                        r_j         <= 2'd0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= OUT_flat[3:0];
                        r_out_last  <= 1'b0;
                        r_state     <= DRAIN;
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (r_j == 2'd3) begin
                            r_j         <= 2'd0;
                            r_out_valid <= 1'b0;
                            r_out_data  <= 4'd0;
                            r_out_last  <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_state     <= LOAD;
                        end else begin
                            r_j        <= w_next_j;
                            r_out_data <= r_res[w_next_lsb +: 4];
                            r_out_last <= (w_next_j == 2'd3);
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign frame_err = r_frame_err;
    assign A_flat    = r_a;
    assign B_flat    = r_b;
    assign C_flat    = r_c;

endmodule

// File: tb/tb_tensor_frame_loader.sv
// Scoreboard bench for tensor_frame_loader with a behavioural MAC core model attached.
// Expected result rows are queued when a frame completes; a negedge monitor pops and compares.
module tb_tensor_frame_loader;

    localparam int SETTLE = 1;

    typedef logic [3:0] mat_t [4];
    typedef struct packed {
        logic [3:0] data;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic        out_last;
    logic        frame_err;
    logic [15:0] A_flat;
    logic [15:0] B_flat;
    logic [15:0] C_flat;
    logic [15:0] OUT_flat;
`ifdef TENSOR_CHAIN_EN
    logic        in_chain;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    mat_t prev_res;
    bit   cur_chain;
    bit   held_v;
    logic [3:0] held_d;
    logic       held_l;

    always #5 clk = ~clk;

    tensor_frame_loader #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
`ifdef TENSOR_CHAIN_EN
        .in_chain  (in_chain),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_err (frame_err),
        .A_flat    (A_flat),
        .B_flat    (B_flat),
        .C_flat    (C_flat),
        .OUT_flat  (OUT_flat)
    );

    // Combinational core: OUT[r][c] = OR_k (A[r][k] & B[k][c]) | C[r][c]
    always_comb begin
        OUT_flat = C_flat;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < 4; k++)
                    if (A_flat[4*r+k] && B_flat[4*k+c]) OUT_flat[4*r+c] = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every handshaked row, and stability while stalled.
    always @(negedge clk) begin
        if (!rst_n || !out_valid) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_data", out_data, held_d);
                check("hold_last", out_last, held_l);
            end
            if (out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h with empty scoreboard", out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", out_last, e.last);
                end
                held_v = 1'b0;
            end else begin
                held_v = 1'b1;
                held_d = out_data;
                held_l = out_last;
            end
        end
    end

    task automatic rand_mat(output mat_t m);
        for (int i = 0; i < 4; i++) m[i] = 4'($urandom);
    endtask

    task automatic send_beat(input logic [3:0] d, input bit last);
        int n;
        n = 0;
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_data  = 4'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
`ifdef TENSOR_CHAIN_EN
        in_chain = cur_chain;
`endif
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("beat_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 4'($urandom);
    endtask

    // mode 0: always ready, 1: random stalls, 2: 5-cycle initial stall, 3: reset after row 1
    task automatic drain(input int mode);
        int  cyc;
        int  hold;
        bit  done;
        cyc  = 0;
        done = 1'b0;
        hold = (mode == 2) ? 5 : 0;
        if (mode == 3) begin
            out_ready = 1'b1;
            repeat (2) begin @(posedge clk); #1; end
            out_ready = 1'b0;
            #1 rst_n = 1'b0;
            #1;
            check("rst_out_valid", out_valid, 0);
            check("rst_A_flat", A_flat, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_out_data", out_data, 0);
            sb.delete();
            for (int r = 0; r < 4; r++) prev_res[r] = 4'd0;
            @(negedge clk); @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk); #1;
            check("rst_release_ready", in_ready, 1);
            return;
        end
        while (!done && cyc < 200) begin
            if (hold > 0) begin
                out_ready = 1'b0;
                hold--;
            end else if (mode == 1) begin
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                out_ready = 1'b1;
            end
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 4'($urandom);
            check("in_ready_drain", in_ready, 0);
            done = out_valid && out_ready && out_last;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("drain_done", done, 1);
        check("in_ready_after_drain", in_ready, 1);
    endtask

    // last_at: beat carrying in_last (-1 = never); early values drop the frame.
    task automatic run_frame(input mat_t a, input mat_t b, input mat_t c,
                             input bit chain, input int last_at, input int mode);
        int         nb;
        int         stop;
        int         n;
        logic [3:0] d;
        mat_t       cc;
        mat_t       res;
        cur_chain = chain;
        nb   = chain ? 8 : 12;
        stop = (last_at >= 0) ? last_at : nb - 1;
        for (int i = 0; i <= stop; i++) begin
            if (i < 4)      d = a[i];
            else if (i < 8) d = b[i-4];
            else            d = c[i-8];
            send_beat(d, i == last_at);
        end
        if (stop < nb - 1) begin
            check("early_err", frame_err, 1);
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                if (i == 0) check("early_err_pulse", frame_err, 0);
                check("early_no_out", out_valid, 0);
            end
            check("early_in_ready", in_ready, 1);
            return;
        end
        cc = chain ? prev_res : c;
        for (int r = 0; r < 4; r++) begin
            res[r] = cc[r];
            for (int k = 0; k < 4; k++)
                if (a[r][k]) res[r] = res[r] | b[k];
            sb.push_back(exp_t'{res[r], (r == 3)});
        end
        prev_res = res;
        check("final_err", frame_err, (last_at == nb - 1) ? 0 : 1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) check("final_err_pulse", frame_err, 0);
        end while (!out_valid && n < 40);
        check("latency", n, SETTLE);
        drain(mode);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        mat_t a_id, b_id, zero, full, c_pt, b_bp, ra, rb, rc;
        int   last_at;
        int   nb;
        bit   ch;
        a_id = '{4'h1, 4'h2, 4'h4, 4'h8};
        b_id = '{4'h3, 4'h5, 4'hA, 4'hC};
        zero = '{4'h0, 4'h0, 4'h0, 4'h0};
        full = '{4'hF, 4'hF, 4'hF, 4'hF};
        c_pt = '{4'hF, 4'h0, 4'hF, 4'h0};
        b_bp = '{4'h1, 4'h0, 4'h0, 4'h0};
        for (int r = 0; r < 4; r++) prev_res[r] = 4'd0;
        cur_chain = 1'b0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
`ifdef TENSOR_CHAIN_EN
        in_chain  = 1'b0;
`endif
        #1 rst_n = 1'b0;
        #2;
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_last", out_last, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_operands", {A_flat, B_flat, C_flat}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", in_ready, 1);

        run_frame(a_id, b_id, zero, 1'b0, 11, 0);   // identity
        run_frame(zero, full, c_pt, 1'b0, 11, 0);   // C passthrough
        run_frame(full, b_bp, zero, 1'b0, 11, 2);   // backpressure
        run_frame(a_id, b_id, zero, 1'b0, 4, 0);    // early in_last, dropped
        run_frame(a_id, b_id, zero, 1'b0, 11, 0);
        rand_mat(ra); rand_mat(rb); rand_mat(rc);
        run_frame(ra, rb, rc, 1'b0, -1, 1);         // missing in_last on beat 11
`ifdef TENSOR_CHAIN_EN
        run_frame(a_id, b_id, zero, 1'b0, 11, 0);
        rand_mat(rb);
        run_frame(zero, rb, zero, 1'b1, 7, 0);      // chained: result = previous
`endif

        for (int t = 0; t < 30; t++) begin
            rand_mat(ra); rand_mat(rb); rand_mat(rc);
            ch = 1'b0;
`ifdef TENSOR_CHAIN_EN
            ch = ($urandom_range(0, 3) == 0);
`endif
            nb = ch ? 8 : 12;
            case ($urandom_range(0, 9))
                0:       last_at = -1;
                1:       last_at = $urandom_range(0, nb - 2);
                default: last_at = nb - 1;
            endcase
            run_frame(ra, rb, rc, ch, last_at, $urandom_range(0, 1));
        end

        run_frame(a_id, b_id, zero, 1'b0, 11, 3);   // reset mid-DRAIN
        run_frame(a_id, b_id, zero, 1'b0, 11, 1);

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
